// File: rtl/clock_min_sec_counter_if.sv
// Control and time-readout bundle of the seconds/minutes stage.
interface clock_min_sec_counter_if;
  logic       key;
  logic       mode_btn;
  logic       inc_btn;
  logic [7:0] sec;
  logic [7:0] min;
  logic       sec_tick;
  logic       hr_tick;
  logic [1:0] set_state;

  modport master (
    output key, mode_btn, inc_btn,
    input  sec, min, sec_tick, hr_tick, set_state
  );

  modport slave (
    input  key, mode_btn, inc_btn,
    output sec, min, sec_tick, hr_tick, set_state
  );
endinterface

// File: rtl/clock_min_sec_counter.sv
// Seconds/minutes timekeeper: 1 Hz prescaler, mod-60 counters, hour carry
// pulse and a debounced two-button time-set mode.
module clock_min_sec_counter #(
  parameter int TICK_DIV   = 1000,
  parameter int DEB_CYCLES = 20
) (
  input  logic                    clk,
  input  logic                    rst,
  clock_min_sec_counter_if.slave  io
);

  localparam int PW = $clog2(TICK_DIV);
  localparam int DW = $clog2(DEB_CYCLES + 1);
  localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_DIV - 1);
  localparam logic [DW-1:0] DEB_MAX   = DW'(DEB_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_RUN     = 2'd0,
    ST_SET_MIN = 2'd1,
    ST_SET_SEC = 2'd2
  } state_e;

  // bit 0 = mode button, bit 1 = increment button
  logic [1:0]    btn_raw_s;
  logic [1:0]    sync1_q, sync2_q, level_q, level_d, prev_q, press_s;
  logic [DW-1:0] deb_cnt_q [2];
  logic [DW-1:0] deb_cnt_d [2];
  logic          mode_p, inc_p;

  state_e        state_q, state_d;
  logic          in_run_s, in_set_min_s, in_set_sec_s;

  logic [PW-1:0] presc_q, presc_d;
  logic [5:0]    sec_q, sec_d, min_q, min_d;
  logic          sec_tick_q, sec_tick_d, hr_tick_q, hr_tick_d;

  assign btn_raw_s = {io.inc_btn, io.mode_btn};
  assign press_s   = level_q & ~prev_q;
  assign mode_p    = press_s[0];
  assign inc_p     = press_s[1];

  // Accepted level flips only after DEB_CYCLES consecutive differing samples.
  always_comb begin
    level_d = level_q;
    for (int b = 0; b < 2; b++) begin
      deb_cnt_d[b] = deb_cnt_q[b];
      if (sync2_q[b] != level_q[b]) begin
        if (deb_cnt_q[b] == DEB_MAX) begin
          level_d[b]   = sync2_q[b];
          deb_cnt_d[b] = {DW{1'b0}};
        end else begin
          deb_cnt_d[b] = deb_cnt_q[b] + DW'(1);
        end
      end else begin
        deb_cnt_d[b] = {DW{1'b0}};
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1_q      <= 2'b00;
      sync2_q      <= 2'b00;
      level_q      <= 2'b00;
      prev_q       <= 2'b00;
      deb_cnt_q[0] <= {DW{1'b0}};
      deb_cnt_q[1] <= {DW{1'b0}};
    end else begin
      sync1_q      <= btn_raw_s;
      sync2_q      <= sync1_q;
      level_q      <= level_d;
      prev_q       <= level_q;
      deb_cnt_q[0] <= deb_cnt_d[0];
      deb_cnt_q[1] <= deb_cnt_d[1];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_RUN;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_RUN: begin
        if (mode_p) state_d = ST_SET_MIN;
        else        state_d = ST_RUN;
      end
      ST_SET_MIN: begin
        if (mode_p) state_d = ST_SET_SEC;
        else        state_d = ST_SET_MIN;
      end
      ST_SET_SEC: begin
        if (mode_p) state_d = ST_RUN;
        else        state_d = ST_SET_SEC;
      end
      default: state_d = ST_RUN;
    endcase
  end

  always_comb begin
    in_run_s     = 1'b0;
    in_set_min_s = 1'b0;
    in_set_sec_s = 1'b0;
    case (state_q)
      ST_RUN:     in_run_s     = 1'b1;
      ST_SET_MIN: in_set_min_s = 1'b1;
      ST_SET_SEC: in_set_sec_s = 1'b1;
      default: begin
        in_run_s     = 1'b0;
        in_set_min_s = 1'b0;
        in_set_sec_s = 1'b0;
      end
    endcase
  end

  // mode_p outranks both the prescaler tick and inc_p; the tick is dropped.
  always_comb begin
    presc_d    = presc_q;
    sec_d      = sec_q;
    min_d      = min_q;
    sec_tick_d = 1'b0;
    hr_tick_d  = 1'b0;
    if (mode_p) begin
      presc_d = {PW{1'b0}};
    end else if (in_run_s) begin
      if (io.key) begin
        if (presc_q == PRESC_MAX) begin
          presc_d    = {PW{1'b0}};
          sec_tick_d = 1'b1;
          if (sec_q == 6'd59) begin
            sec_d = 6'd0;
            if (min_q == 6'd59) begin
              min_d     = 6'd0;
              hr_tick_d = 1'b1;
            end else begin
              min_d = min_q + 6'd1;
            end
          end else begin
            sec_d = sec_q + 6'd1;
          end
        end else begin
          presc_d = presc_q + PW'(1);
        end
      end else begin
        presc_d = presc_q;
      end
    end else if (in_set_min_s) begin
      if (inc_p) min_d = (min_q == 6'd59) ? 6'd0 : min_q + 6'd1;
      else       min_d = min_q;
    end else if (in_set_sec_s) begin
      if (inc_p) sec_d = (sec_q == 6'd59) ? 6'd0 : sec_q + 6'd1;
      else       sec_d = sec_q;
    end else begin
      presc_d = {PW{1'b0}};
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      presc_q    <= {PW{1'b0}};
      sec_q      <= 6'd0;
      min_q      <= 6'd0;
      sec_tick_q <= 1'b0;
      hr_tick_q  <= 1'b0;
    end else begin
      presc_q    <= presc_d;
      sec_q      <= sec_d;
      min_q      <= min_d;
      sec_tick_q <= sec_tick_d;
      hr_tick_q  <= hr_tick_d;
    end
  end

  assign io.sec       = {2'b00, sec_q};
  assign io.min       = {2'b00, min_q};
  assign io.sec_tick  = sec_tick_q;
  assign io.hr_tick   = hr_tick_q;
  assign io.set_state = state_q;

endmodule
